// File: rtl/dot_product_seq_if.sv
// Stream bundle for dot_product_seq: pair input stream plus held result output.
// The slave modport is the engine's view; master is the source/consumer side.
interface dot_product_seq_if #(
   parameter int W = 8
);
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   a_in;
   logic [W-1:0]   b_in;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] result;

   modport master (
      output in_valid, a_in, b_in, out_ready,
      input  in_ready, out_valid, result
   );

   modport slave (
      input  in_valid, a_in, b_in, out_ready,
      output in_ready, out_valid, result
   );
endinterface

// File: rtl/dot_product_seq.sv
// Sequenced dot product: one shared WxW multiplier, N pairs in, one 2W-bit sum out.
// Optional macro DOT_SAT_EN: saturate the result instead of wrapping modulo 2^(2W).
module dot_product_seq #(
   parameter int N = 8,
   parameter int W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   output logic              busy,
   dot_product_seq_if.slave  bus
);
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int AW = 2 * W + $clog2(N);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t         state, state_n;
   logic [AW-1:0]  acc, acc_n;
   logic [CW-1:0]  count, count_n;
   logic [2*W-1:0] res_q, res_n;

   logic [AW-1:0]  prod;
   logic [AW-1:0]  sum;
   logic [2*W-1:0] final_res;
   logic           accept;
   logic           deliver;

   assign bus.in_ready  = (state != DONE);
   assign bus.out_valid = (state == DONE);
   assign bus.result    = res_q;
   assign busy          = (state != IDLE);

   assign accept  = bus.in_valid && bus.in_ready;
   assign deliver = bus.out_valid && bus.out_ready;
   assign prod    = AW'(bus.a_in) * AW'(bus.b_in);
   assign sum     = acc + prod;

`ifdef DOT_SAT_EN
   assign final_res = (|sum[AW-1:2*W]) ? {(2*W){1'b1}} : sum[2*W-1:0];
`else
   assign final_res = sum[2*W-1:0];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         count <= '0;
         res_q <= '0;
      end else begin
         state <= state_n;
         acc   <= acc_n;
         count <= count_n;
         res_q <= res_n;
      end
   end

   // clr is applied last so it overrides any same-cycle acceptance or delivery
   always_comb begin
      state_n = state;
      acc_n   = acc;
      count_n = count;
      res_n   = res_q;
      case (state)
         IDLE: begin
            if (accept) begin
               acc_n   = prod;
               count_n = CW'(1);
               state_n = ACCUM;
            end
         end
         ACCUM: begin
            if (accept) begin
               acc_n = sum;
               if (count == CW'(N - 1)) begin
                  res_n   = final_res;
                  count_n = '0;
                  state_n = DONE;
               end else begin
                  count_n = count + CW'(1);
               end
            end
         end
         DONE: begin
            if (deliver) begin
               acc_n   = '0;
               count_n = '0;
               state_n = IDLE;
            end
         end
         default: begin
            acc_n   = '0;
            count_n = '0;
            state_n = IDLE;
         end
      endcase
      if (clr) begin
         acc_n   = '0;
         count_n = '0;
         res_n   = '0;
         state_n = IDLE;
      end
   end
endmodule

// File: tb/tb_dot_product_seq.sv
// Directed self-checking bench for dot_product_seq (N=8, W=8).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_dot_product_seq;
   logic clk;
   logic rst;
   logic clr;
   logic busy;

   int checks;
   int passes;

   logic [7:0]  va [8];
   logic [7:0]  vb [8];
   logic [31:0] exp_ovf;

   dot_product_seq_if #(.W(8)) bus ();

   dot_product_seq #(.N(8), .W(8)) dut (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .busy (busy),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic v);
      bus.a_in     = a;
      bus.b_in     = b;
      bus.in_valid = v;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
      checkOutput({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
      checkOutput({tag, " busy"}, 32'(busy), 32'd0);
   endtask

   // Sends va/vb; with gaps an idle cycle follows every pair except the last
   task automatic sendVector(input bit gapped);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(va[i], vb[i], 1'b1);
         checkOutput("accept in_ready", 32'(bus.in_ready), 32'd1);
         step();
         if (gapped && i < 7) begin
            applyStimulus(8'd0, 8'd0, 1'b0);
            checkOutput("gap out_valid", 32'(bus.out_valid), 32'd0);
            step();
         end
      end
      applyStimulus(8'd0, 8'd0, 1'b0);
   endtask

   task automatic loadRamp();
      for (int i = 0; i < 8; i++) begin
         va[i] = 8'(i + 1);
         vb[i] = 8'd2;
      end
   endtask

   initial begin
      checks = 0;
      passes = 0;
      rst = 1'b1;
      clr = 1'b0;
      bus.out_ready = 1'b0;
      applyStimulus(8'd0, 8'd0, 1'b0);
      step();
      step();
      rst = 1'b0;
      checkIdle("reset");
      checkOutput("reset result", 32'(bus.result), 32'd0);

      // Basic: 1..8 times 2 = 72, consumer always ready
      loadRamp();
      bus.out_ready = 1'b1;
      sendVector(1'b0);
      checkOutput("basic out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("basic result", 32'(bus.result), 32'd72);
      checkOutput("basic in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("basic busy", 32'(busy), 32'd1);
      step();
      checkIdle("basic drained");

      // Backpressure: result held, input pulses ignored
      bus.out_ready = 1'b0;
      sendVector(1'b0);
      for (int k = 0; k < 5; k++) begin
         applyStimulus(8'd99, 8'd99, k[0] ? 1'b0 : 1'b1);
         checkOutput("bp out_valid", 32'(bus.out_valid), 32'd1);
         checkOutput("bp result", 32'(bus.result), 32'd72);
         checkOutput("bp in_ready", 32'(bus.in_ready), 32'd0);
         step();
      end
      applyStimulus(8'd0, 8'd0, 1'b0);
      bus.out_ready = 1'b1;
      checkOutput("bp still held", 32'(bus.out_valid), 32'd1);
      step();
      bus.out_ready = 1'b0;
      checkIdle("bp drained");

      // Gapped: same sum, out_valid right after last acceptance
      sendVector(1'b1);
      checkOutput("gap done out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("gap result", 32'(bus.result), 32'd72);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      checkIdle("gap drained");

      // Overflow: 8 * 255 * 255 = 520200
      for (int i = 0; i < 8; i++) begin
         va[i] = 8'd255;
         vb[i] = 8'd255;
      end
`ifdef DOT_SAT_EN
      exp_ovf = 32'd65535;
`else
      exp_ovf = 32'(520200 % 65536);
`endif
      sendVector(1'b0);
      checkOutput("overflow result", 32'(bus.result), exp_ovf);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;

      // Abort on the 5th acceptance, then a fresh all-ones vector
      for (int i = 0; i < 4; i++) begin
         applyStimulus(8'd3, 8'd3, 1'b1);
         step();
      end
      applyStimulus(8'd50, 8'd50, 1'b1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      applyStimulus(8'd0, 8'd0, 1'b0);
      checkIdle("abort");
      for (int i = 0; i < 8; i++) begin
         va[i] = 8'd1;
         vb[i] = 8'd1;
      end
      sendVector(1'b0);
      checkOutput("abort result", 32'(bus.result), 32'd8);
      checkOutput("abort out_valid", 32'(bus.out_valid), 32'd1);
      clr = 1'b1;
      bus.out_ready = 1'b1;
      step();
      clr = 1'b0;
      bus.out_ready = 1'b0;
      checkIdle("clr in done");

      // Reset mid-accumulation and in DONE
      for (int i = 0; i < 3; i++) begin
         applyStimulus(8'd7, 8'd7, 1'b1);
         step();
      end
      applyStimulus(8'd0, 8'd0, 1'b0);
      checkOutput("pre-rst busy", 32'(busy), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      checkIdle("rst accum");
      checkOutput("rst accum result", 32'(bus.result), 32'd0);
      for (int i = 0; i < 8; i++) begin
         va[i] = 8'(i + 1);
         vb[i] = 8'(8 - i);
      end
      sendVector(1'b0);
      checkOutput("post-rst result", 32'(bus.result), 32'd120);
      rst = 1'b1;
      step();
      rst = 1'b0;
      checkIdle("rst done");
      checkOutput("rst done result", 32'(bus.result), 32'd0);
      loadRamp();
      sendVector(1'b0);
      checkOutput("final result", 32'(bus.result), 32'd72);
      checkOutput("final out_valid", 32'(bus.out_valid), 32'd1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
